risc_v_fetch: RTL and testbench
===============================

// Module: risc_v_fetch
// PURPOSE
//   Instruction fetch stage directly upstream of the control/decode unit. Holds the PC and
//   fetches one word per instruction from instruction memory with a req/ack handshake.
//   Presents the instruction and pre-split fields (opcode, funct3, funct7 bit, rd, rs1, rs2)
//   to decode with a valid/ready handshake. Accepts PC redirects from branch/jump resolution.
// PARAMETERS
//   WORD_LENGTH  32          datapath/PC/instruction width
//   RESET_PC     32'h0       PC value loaded on reset
//   NOP_INSTR    32'h13      instr value while nothing is valid (addi x0,x0,0)
// PORTS
//   clk             in   1            clock, all state updates on posedge
//   rst             in   1            synchronous reset, active-high
//   imem_req        out  1            fetch request to instruction memory
//   imem_addr       out  WORD_LENGTH  fetch address, word aligned
//   imem_ack        in   1            memory returns imem_rdata this cycle
//   imem_rdata      in   WORD_LENGTH  fetched instruction word
//   redirect_valid  in   1            load new PC (branch/jump taken)
//   redirect_pc     in   WORD_LENGTH  target PC; bits [1:0] ignored
//   instr_valid     out  1            instr/fields/pc_out valid for decode
//   instr_ready     in   1            decode consumes instruction this cycle
//   instr           out  WORD_LENGTH  instruction word
//   pc_out          out  WORD_LENGTH  PC of instr
//   opcode          out  7            instr[6:0]
//   rd              out  5            instr[11:7]
//   funct3          out  3            instr[14:12]
//   rs1             out  5            instr[19:15]
//   rs2             out  5            instr[24:20]
//   funct7          out  1            instr[30] (only funct7 bit used by decode)
//   fetch_count     out  32           number of instructions accepted by decode
// BEHAVIOUR
//   - Reset: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=NOP_INSTR,
//     pc_out=RESET_PC, fetch_count=0. Reset mid-transaction drops everything; late ack ignored.
//   - Field outputs are pure wiring from the instr register; imem_req=(state==REQ||state==DRAIN).
//   - imem_addr = pc in REQ, = latched old address in DRAIN; stable while req && !ack.
//   - FSM: IDLE -> REQ on first cycle with rst=0.
//     REQ: on imem_ack: instr<=imem_rdata, pc_out<=pc, pc<=pc+4, instr_valid<=1 -> VALID.
//     VALID: on instr_ready: instr_valid<=0, fetch_count+=1 -> REQ (next req next cycle).
//     DRAIN: on imem_ack: discard data -> REQ with redirected pc.
//   - Latency: ack in cycle N => instr_valid high in cycle N+1; zero-wait memory and
//     instr_ready=1 give one instruction per 2 cycles.
//   - Redirect (highest priority, ignored in IDLE): pc<={redirect_pc[WL-1:2],2'b00}.
//     In VALID: instr_valid<=0, instr<=NOP_INSTR, no fetch_count increment even if
//     instr_ready=1 the same cycle; -> REQ.
//     In REQ with imem_ack same cycle: data discarded -> REQ (new pc).
//     In REQ without ack: -> DRAIN (old address held until ack).
//     In DRAIN: pc updated to latest target, stay DRAIN.
//   - pc+4 and fetch_count wrap modulo 2^width silently.
//   - instr/pc_out/fields stable while instr_valid && !instr_ready.
// TESTING
//   - Reset then imem_ack=1 always, rdata=addr-tagged, instr_ready=1 -> addrs 0,4,8,..;
//     instr_valid every 2nd cycle; fetch_count=3 after 3 handshakes.
//   - Hold instr_ready=0 for 5 cycles with instr=32'h00B50533 -> outputs stable,
//     imem_req=0, opcode=7'h33, rd=10, rs1=10, rs2=11, funct3=0, funct7=0.
//   - Redirect to 32'h103 while VALID with instr_ready=1 -> instr_valid=0 next cycle,
//     fetch_count unchanged, next imem_addr=32'h100.
//   - ack delayed 3 cycles, redirect to 32'h200 in first REQ cycle -> addr held until ack,
//     data discarded, next request addr=32'h200.
//   - RESET_PC=32'hFFFF_FFFC, ack -> next fetch addr 32'h0 (wrap).
//   - rst asserted in DRAIN with ack arriving same cycle -> all outputs at reset values.

Source files
------------

// File: rtl/risc_v_fetch.sv
// risc_v_fetch -- instruction fetch stage feeding the control/decode unit.
//
// Holds the PC, fetches one word per instruction over a req/ack memory port
// and presents it, with its PC and pre-split fields, to decode over valid/ready.
// Branch/jump resolution can redirect the PC at any time after reset.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   imem_req/addr   fetch request and word-aligned address
//   imem_ack/rdata  memory response (data valid in the ack cycle)
//   redirect_*      new PC from branch/jump resolution (bits [1:0] ignored)
//   instr_valid     instr/pc_out/fields valid for decode
//   instr_ready     decode consumes the instruction this cycle
//   instr, pc_out   instruction word and its PC
//   opcode..funct7  fields wired straight from the instr register
//   fetch_count     instructions accepted by decode (wraps)
module risc_v_fetch #(
  parameter int                     WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] RESET_PC    = '0,
  parameter logic [WORD_LENGTH-1:0] NOP_INSTR   = WORD_LENGTH'(32'h13)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [WORD_LENGTH-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [WORD_LENGTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [WORD_LENGTH-1:0] redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [WORD_LENGTH-1:0] instr,
  output logic [WORD_LENGTH-1:0] pc_out,
  output logic [6:0]             opcode,
  output logic [4:0]             rd,
  output logic [2:0]             funct3,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic                   funct7,
  output logic [31:0]            fetch_count
);

  typedef enum logic [1:0] {IDLE, REQ, VALID, DRAIN} state_t;

  state_t                 state, state_n;
  logic [WORD_LENGTH-1:0] pc, pc_n;
  logic [WORD_LENGTH-1:0] drain_addr, drain_addr_n;
  logic [WORD_LENGTH-1:0] instr_n, pc_out_n;
  logic                   instr_valid_n;
  logic [31:0]            fetch_count_n;
  logic [WORD_LENGTH-1:0] redir_pc;

  assign redir_pc = {redirect_pc[WORD_LENGTH-1:2], 2'b00};

  // A request that was already issued must complete on the bus before the
  // redirected PC can be fetched, so DRAIN keeps presenting the old address.
  assign imem_req  = (state == REQ) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[30];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drain_addr  <= RESET_PC;
      instr       <= NOP_INSTR;
      pc_out      <= RESET_PC;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      drain_addr  <= drain_addr_n;
      instr       <= instr_n;
      pc_out      <= pc_out_n;
      instr_valid <= instr_valid_n;
      fetch_count <= fetch_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    drain_addr_n  = drain_addr;
    instr_n       = instr;
    pc_out_n      = pc_out;
    instr_valid_n = instr_valid;
    fetch_count_n = fetch_count;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (redirect_valid) begin
          pc_n = redir_pc;
          // With ack the stale word is simply dropped; without it the
          // outstanding request still has to be drained.
          if (!imem_ack) begin
            drain_addr_n = pc;
            state_n      = DRAIN;
          end
        end else if (imem_ack) begin
          instr_n       = imem_rdata;
          pc_out_n      = pc;
          pc_n          = pc + WORD_LENGTH'(4);
          instr_valid_n = 1'b1;
          state_n       = VALID;
        end
      end
      VALID: begin
        if (redirect_valid) begin
          // Squash: the held instruction is on the wrong path, not consumed.
          pc_n          = redir_pc;
          instr_valid_n = 1'b0;
          instr_n       = NOP_INSTR;
          state_n       = REQ;
        end else if (instr_ready) begin
          instr_valid_n = 1'b0;
          instr_n       = NOP_INSTR;
          fetch_count_n = fetch_count + 32'd1;
          state_n       = REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_n = redir_pc;
        else if (imem_ack)  state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_risc_v_fetch.sv
// Directed bench for risc_v_fetch: inputs driven and outputs sampled on negedge.
module tb_risc_v_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, redirect_valid, instr_valid, instr_ready, funct7;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, pc_out, fetch_count;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        auto_data;
  logic [31:0] rdata_man;

  // second instance exercising PC wrap
  logic        w_req, w_ack, w_valid, w_ready, w_f7;
  logic [31:0] w_addr, w_instr, w_pc_out, w_cnt;
  logic [6:0]  w_op;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  assign imem_rdata = auto_data ? (32'h1000_0000 | imem_addr) : rdata_man;

  risc_v_fetch u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc_out(pc_out), .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .funct7(funct7), .fetch_count(fetch_count));

  risc_v_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(32'h0000_0013), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .instr_valid(w_valid), .instr_ready(w_ready),
    .instr(w_instr), .pc_out(w_pc_out), .opcode(w_op), .rd(w_rd), .funct3(w_f3),
    .rs1(w_rs1), .rs2(w_rs2), .funct7(w_f7), .fetch_count(w_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; auto_data = 1'b1; rdata_man = '0;
    w_ack = 1'b0; w_ready = 1'b0;
    step(); step();

    // reset state
    chk("rst_req",   {31'b0, imem_req},    32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr,                32'h13);
    chk("rst_pcout", pc_out,               32'h0);
    chk("rst_cnt",   fetch_count,          32'h0);

    // streaming: zero-wait memory, decode always ready
    rst = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("str_req",    {31'b0, imem_req},    32'd1);
      chk("str_addr",   imem_addr,            32'(4 * i));
      chk("str_nvalid", {31'b0, instr_valid}, 32'd0);
      step();
      chk("str_valid",  {31'b0, instr_valid}, 32'd1);
      chk("str_instr",  instr,                32'h1000_0000 | 32'(4 * i));
      chk("str_pcout",  pc_out,               32'(4 * i));
      step();
    end
    chk("str_cnt",  fetch_count, 32'd3);
    chk("str_addr3", imem_addr,  32'd12);

    // backpressure: hold instr_ready low
    auto_data = 1'b0; rdata_man = 32'h00B5_0533; instr_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_instr", instr,                32'h00B5_0533);
      chk("hold_pcout", pc_out,               32'd12);
      chk("hold_req",   {31'b0, imem_req},    32'd0);
      step();
    end
    chk("f_opcode", {25'b0, opcode}, 32'h33);
    chk("f_rd",     {27'b0, rd},     32'd10);
    chk("f_rs1",    {27'b0, rs1},    32'd10);
    chk("f_rs2",    {27'b0, rs2},    32'd11);
    chk("f_funct3", {29'b0, funct3}, 32'd0);
    chk("f_funct7", {31'b0, funct7}, 32'd0);
    chk("hold_cnt", fetch_count,     32'd3);

    // redirect while VALID, decode ready the same cycle
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    chk("rv_valid", {31'b0, instr_valid}, 32'd0);
    chk("rv_cnt",   fetch_count,          32'd3);
    chk("rv_addr",  imem_addr,            32'h100);
    chk("rv_instr", instr,                32'h13);

    // redirect in first REQ cycle while memory is slow
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    rdata_man = 32'hDEAD_BEEF;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("dr_req",  {31'b0, imem_req}, 32'd1);
      chk("dr_addr", imem_addr,         32'h100);
      step();
    end
    imem_ack = 1'b1;
    step();
    chk("dr_valid", {31'b0, instr_valid}, 32'd0);
    chk("dr_naddr", imem_addr,            32'h200);
    chk("dr_nreq",  {31'b0, imem_req},    32'd1);
    rdata_man = 32'h00C5_8593;
    step();
    chk("dr_fvalid", {31'b0, instr_valid}, 32'd1);
    chk("dr_finstr", instr,                32'h00C5_8593);
    chk("dr_fpcout", pc_out,               32'h200);
    imem_ack = 1'b0;
    step();
    chk("dr_cnt",  fetch_count, 32'd4);
    chk("dr_addr4", imem_addr,  32'h204);

    // reset while DRAIN with ack arriving the same cycle
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    chk("rd_drain", imem_addr, 32'h204);
    rst = 1'b1; imem_ack = 1'b1;
    step();
    chk("rd_req",   {31'b0, imem_req},    32'd0);
    chk("rd_valid", {31'b0, instr_valid}, 32'd0);
    chk("rd_instr", instr,                32'h13);
    chk("rd_pcout", pc_out,               32'h0);
    chk("rd_cnt",   fetch_count,          32'h0);

    // release reset; wrap instance fetches at top of address space
    rst = 1'b0; imem_ack = 1'b0; w_ack = 1'b1;
    step();
    chk("rd_addr0", imem_addr, 32'h0);
    chk("w_addr0",  w_addr,    32'hFFFF_FFFC);
    step();
    chk("w_valid",  {31'b0, w_valid}, 32'd1);
    chk("w_pcout",  w_pc_out,         32'hFFFF_FFFC);
    w_ready = 1'b1;
    step();
    chk("w_wrap",   w_addr,           32'h0);
    chk("w_req",    {31'b0, w_req},   32'd1);
    chk("w_cnt",    w_cnt,            32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
